mem_access_unit: RTL and testbench

Multicycle load/store engine between the main controller and the external memory bus. The controller issues a read or write request with address, data and funct3. The unit handles the following:
- byte-lane alignment and write strobes;
- the bus request/acknowledge handshake with a timeout;
- sign/zero extension of load data.

It reports busy, done and fault back to the controller, which holds its memory state while busy is high.

---
 rtl/mem_access_unit.sv | 230 +++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: multicycle load/store engine between the controller and the memory bus.
// Handles byte-lane alignment and write strobes, the request/ack handshake with a timeout,
// and sign/zero extension of load data.
// Ports:
//   clk, rst (sync, active-low)
//   req_rd/req_wr, addr, wdata, funct3     : request from controller (sampled in IDLE only)
//   busy, done, rdata, fault, fault_cause  : status back to controller
//   bus_req/bus_we/bus_addr/bus_be/bus_wdata, bus_rdata/bus_ack : external memory bus
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_BUS, S_WAIT, S_DONE, S_ERR
    } state_t;

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [2:0]         funct3_q, funct3_d;
    logic               we_q, we_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               fault_q, fault_d;
    logic [1:0]         cause_q, cause_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               bus_req_q, bus_req_d;
    logic               bus_we_q, bus_we_d;
    logic [31:0]        bus_addr_q, bus_addr_d;
    logic [3:0]         bus_be_q, bus_be_d;
    logic [31:0]        bus_wdata_q, bus_wdata_d;

    logic               illegal;
    logic               misaligned;
    logic [3:0]         be_calc;
    logic [31:0]        wdata_rep;
    logic [31:0]        lane;
    logic [31:0]        load_ext;

    // Access decode from the latched request: legality, alignment, lanes, load extension
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        be_calc    = 4'b1111;
        wdata_rep  = wdata_q;
        lane       = bus_rdata >> {addr_q[1:0], 3'b000};
        load_ext   = lane;
        if (we_q) begin
            illegal = (funct3_q != 3'b000) && (funct3_q != 3'b001) && (funct3_q != 3'b010);
        end else begin
            illegal = (funct3_q == 3'b011) || (funct3_q[2:1] == 2'b11);
        end
        case (funct3_q[1:0])
            2'b00: begin
                be_calc   = 4'b0001 << addr_q[1:0];
                wdata_rep = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                misaligned = addr_q[0];
                be_calc    = 4'b0011 << addr_q[1:0];
                wdata_rep  = {2{wdata_q[15:0]}};
            end
            default: begin
                misaligned = (addr_q[1:0] != 2'b00);
            end
        endcase
        case (funct3_q)
            3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b100:  load_ext = {24'h0, lane[7:0]};
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b101:  load_ext = {16'h0, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        funct3_d    = funct3_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        cause_d     = cause_q;
        rdata_d     = rdata_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_rd || req_wr) begin
                    addr_d   = addr;
                    wdata_d  = wdata;
                    funct3_d = funct3;
                    we_d     = req_wr;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (illegal) begin
                    cause_d = CAUSE_ILLEGAL;
                    state_d = S_ERR;
                end else if (misaligned) begin
                    cause_d = CAUSE_MISALIGN;
                    state_d = S_ERR;
                end else begin
                    bus_req_d   = 1'b1;
                    bus_we_d    = we_q;
                    bus_addr_d  = {addr_q[31:2], 2'b00};
                    bus_be_d    = be_calc;
                    bus_wdata_d = wdata_rep;
                    state_d     = S_BUS;
                end
            end
            S_BUS, S_WAIT: begin
                if (state_q == S_BUS) begin
                    cnt_d = '0;
                end
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    if (!we_q) begin
                        rdata_d = load_ext;
                    end
                    state_d = S_DONE;
                end else if (state_q == S_BUS) begin
                    state_d = S_WAIT;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    bus_req_d = 1'b0;
                    cause_d   = CAUSE_TIMEOUT;
                    state_d   = S_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE, S_ERR: begin
                bus_be_d = 4'b0000;
                state_d  = S_IDLE;
            end
            default: begin
                bus_req_d = 1'b0;
                bus_be_d  = 4'b0000;
                state_d   = S_IDLE;
            end
        endcase

        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        fault_d = (state_d == S_ERR);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            funct3_q    <= '0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            cause_q     <= 2'b00;
            rdata_q     <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            funct3_q    <= funct3_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            cause_q     <= cause_d;
            rdata_q     <= rdata_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign fault       = fault_q;
    assign fault_cause = cause_q;
    assign rdata       = rdata_q;
    assign bus_req     = bus_req_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_be      = bus_be_q;
    assign bus_wdata   = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized accesses against a behavioural model of
// mem_access_unit (lanes, extension, fault causes, latency, handshake timing).
module tb_mem_access_unit;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_rd, req_wr;
    logic [31:0] addr, wdata;
    logic [2:0]  funct3;
    logic        busy, done, fault;
    logic [31:0] rdata;
    logic [1:0]  fault_cause;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        bus_ack;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_rdata = '0;
    logic [1:0]  exp_cause = 2'b00;

    mem_access_unit #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_rd(req_rd), .req_wr(req_wr), .addr(addr), .wdata(wdata), .funct3(funct3),
        .busy(busy), .done(done), .rdata(rdata), .fault(fault), .fault_cause(fault_cause),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Expected fault cause from the access rules; 0 means the access goes to the bus
    function automatic logic [1:0] model_cause(input logic we, input logic [2:0] f3,
                                               input logic [31:0] a);
        int nbytes;
        if (we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6)) return 2'b11;
        nbytes = 1 << f3[1:0];
        if ((a % nbytes) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int nbytes;
        nbytes = 1 << f3[1:0];
        return 4'(((1 << nbytes) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3[1:0] == 2'd0) return {24'h0, d[7:0]} * 32'h0101_0101;
        if (f3[1:0] == 2'd1) return {16'h0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] d);
        int nbytes;
        logic [31:0] v, mask;
        nbytes = 1 << f3[1:0];
        v = d >> (8 * (a % 4));
        if (nbytes == 4) return v;
        mask = (32'h1 << (8 * nbytes)) - 32'h1;
        v = v & mask;
        if (!f3[2] && v[8*nbytes-1]) v = v | ~mask;
        return v;
    endfunction

    // One access: ack_at = WAIT cycle (1-based) carrying bus_ack, 0 = never ack.
    // noise drives random read requests while the unit is busy.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd, input logic [2:0] f3, input int ack_at,
                              input logic [31:0] rd_data, input logic noise);
        logic        we;
        logic [1:0]  cause;
        int          edges, reqcnt, exp_lat, exp_req;
        logic        got_done, got_fault, finished;
        we = wr;
        cause = model_cause(we, f3, a);
        if (cause != 2'b00) begin
            exp_lat = 2; exp_req = 0;
        end else if (ack_at >= 1 && ack_at <= int'(TO)) begin
            exp_lat = 3 + ack_at; exp_req = ack_at + 1;
        end else begin
            cause = 2'b10; exp_lat = 3 + int'(TO); exp_req = int'(TO) + 1;
        end

        @(negedge clk);
        req_rd = rd; req_wr = wr; addr = a; wdata = wd; funct3 = f3; bus_rdata = rd_data;
        @(negedge clk);
        req_rd = 1'b0; req_wr = 1'b0;
        addr = $urandom; wdata = $urandom; funct3 = 3'($urandom);
        edges = 1; reqcnt = 0; got_done = 0; got_fault = 0; finished = 0;
        for (int i = 0; i < 60 && !finished; i++) begin
            bus_ack = 1'b0;
            if (done || fault) begin
                got_done = done; got_fault = fault; finished = 1;
                req_rd = 1'b0;
            end else begin
                if (bus_req) begin
                    reqcnt++;
                    check_eq("bus_we", 32'(bus_we), 32'(we));
                    check_eq("bus_addr", bus_addr, {a[31:2], 2'b00});
                    check_eq("bus_be", 32'(bus_be), 32'(model_be(f3, a)));
                    if (we) check_eq("bus_wdata", bus_wdata, model_wdata(f3, wd));
                    bus_ack = (ack_at > 0) && (reqcnt == ack_at + 1);
                end
                if (noise) req_rd = 1'($urandom);
                @(negedge clk);
                edges++;
            end
        end
        bus_ack = 1'b0;
        req_rd = 1'b0;
        check_eq("finished", 32'(finished), 32'd1);
        check_eq("latency", 32'(edges), 32'(exp_lat));
        check_eq("done", 32'(got_done), 32'(cause == 2'b00));
        check_eq("fault", 32'(got_fault), 32'(cause != 2'b00));
        check_eq("bus_req_cycles", 32'(reqcnt), 32'(exp_req));
        check_eq("bus_req_dropped", 32'(bus_req), 32'd0);
        if (cause != 2'b00) exp_cause = cause;
        else if (!we) exp_rdata = model_load(f3, a, rd_data);
        check_eq("fault_cause", 32'(fault_cause), 32'(exp_cause));
        check_eq("rdata", rdata, exp_rdata);
        @(negedge clk);
        check_eq("pulse_low", 32'(done | fault), 32'd0);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_be", 32'(bus_be), 32'd0);
    endtask

    initial begin
        rst = 1'b0; req_rd = 0; req_wr = 0; addr = 0; wdata = 0; funct3 = 0;
        bus_rdata = 0; bus_ack = 0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_bus_req", 32'(bus_req), 32'd0);
        check_eq("rst_bus_be", 32'(bus_be), 32'd0);
        check_eq("rst_bus_addr", bus_addr, 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_cause", 32'(fault_cause), 32'd0);
        rst = 1'b1;

        // Reset mid-WAIT, then a stray ack in IDLE
        @(negedge clk);
        req_rd = 1; addr = 32'h40; funct3 = 3'b010;
        @(negedge clk);
        req_rd = 0;
        repeat (4) @(negedge clk);
        check_eq("pre_rst_bus_req", 32'(bus_req), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_bus_req", 32'(bus_req), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        repeat (2) begin
            check_eq("stray_ack_quiet", 32'(done | fault | busy), 32'd0);
            @(negedge clk);
        end

        // Directed cases
        run_access(1, 0, 32'h1003, 32'h0, 3'b000, 1, 32'h80FF_1234, 0);
        check_eq("lb_value", rdata, 32'hFFFF_FF80);
        run_access(1, 0, 32'h1003, 32'h0, 3'b100, 1, 32'h80FF_1234, 0);
        check_eq("lbu_value", rdata, 32'h0000_0080);
        run_access(0, 1, 32'h2002, 32'h0000_BEEF, 3'b001, 3, 32'h0, 0);
        run_access(1, 0, 32'h0006, 32'h0, 3'b010, 1, 32'hDEAD_BEEF, 0);
        check_eq("misalign_cause", 32'(fault_cause), 32'd1);
        run_access(0, 1, 32'h0000, 32'h1234, 3'b011, 1, 32'h0, 0);
        check_eq("illegal_cause", 32'(fault_cause), 32'd3);
        run_access(1, 0, 32'h0010, 32'h0, 3'b001, 0, 32'h0000_8001, 0);
        check_eq("timeout_cause", 32'(fault_cause), 32'd2);
        run_access(1, 0, 32'h0010, 32'h0, 3'b001, int'(TO), 32'h0000_8001, 0);
        check_eq("last_cycle_ack", rdata, 32'hFFFF_8001);
        run_access(1, 1, 32'h0020, 32'hCAFE_F00D, 3'b010, 2, 32'h0, 0);
        run_access(1, 0, 32'h0022, 32'h0, 3'b101, 2, 32'h9876_5432, 1);

        // Randomized accesses
        for (int n = 0; n < 80; n++) begin
            logic        rd, wr;
            logic [31:0] a;
            int          ack_at;
            wr = 1'($urandom);
            rd = wr ? 1'($urandom) : 1'b1;
            a = $urandom;
            ack_at = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5));
            run_access(rd, wr, a, $urandom, 3'($urandom), ack_at, $urandom, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
